// File: rtl/qtree_stream_rx_pkg.sv
// Shared QTree token types for the stream receive path.
// Holds the 67-bit token type, the {last, data} beat and FSM states.
package qtree_stream_package;

  localparam int QTREE_W = 67;

  typedef logic [QTREE_W-1:0] QTree_Int_t;

  typedef struct packed {
    logic       last;
    QTree_Int_t data;
  } QTreeBeat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } rx_state_t;

endpackage

// File: rtl/qtree_stream_rx_fifo.sv
// Synchronous FIFO of QTree beats with occupancy output.
// Ports: clk/rst, i_push/i_beat in, i_pop/o_beat out, o_level.
module qtree_fifo
  import qtree_stream_package::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  QTreeBeat_t               i_beat,
  input  logic                     i_pop,
  output QTreeBeat_t               o_beat,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  QTreeBeat_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [LW-1:0]   r_level;
  logic            w_push;
  logic            w_pop;

  assign w_push  = i_push && (r_level != FULL);
  assign w_pop   = i_pop && (r_level != '0);
  assign o_beat  = r_mem[r_rd];
  assign o_level = r_level;

  // Storage is not reset; stale entries are unreachable once level is 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_beat;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/qtree_stream_rx.sv
// QTree token receiver: buffers upstream beats and measures tree lengths.
// Ports: s_* AXIS-like input, m_* output, frame_done/frame_len/len_err, level.
module qtree_stream_rx
  import qtree_stream_package::*;
#(
  parameter int DEPTH = 8,
  parameter int LEN_W = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  QTree_Int_t              s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output QTree_Int_t              m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic                    frame_done,
  output logic [LEN_W-1:0]        frame_len,
  output logic                    len_err,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]    FULL    = LW'(DEPTH);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  rx_state_t        r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_frame_len;
  logic             r_frame_done;
  logic             r_len_err;
  logic             r_en;

  logic             w_push;
  logic             w_pop;
  logic [LW-1:0]    w_level;
  QTreeBeat_t       w_in;
  QTreeBeat_t       w_out;

  // r_en keeps s_tready low during reset and the cycle it releases.
  assign s_tready = r_en && (w_level != FULL);
  assign m_tvalid = (w_level != '0);
  assign w_push   = s_tvalid && s_tready;
  assign w_pop    = m_tvalid && m_tready;

  assign w_in.last = s_tlast;
  assign w_in.data = s_tdata;

  assign m_tdata    = w_out.data;
  assign m_tlast    = w_out.last;
  assign level      = w_level;
  assign frame_done = r_frame_done;
  assign frame_len  = r_frame_len;
  assign len_err    = r_len_err;

  qtree_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .i_push  (w_push),
    .i_beat  (w_in),
    .i_pop   (w_pop),
    .o_beat  (w_out),
    .o_level (w_level)
  );

  // r_cnt holds tokens delivered so far in the current tree.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_frame_len  <= '0;
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
      r_en         <= 1'b0;
    end else begin
      r_en         <= 1'b1;
      r_frame_done <= 1'b0;
      if (w_pop) begin
        // Another token on a saturated count overflows the tree length.
        if (r_cnt == CNT_MAX) r_len_err <= 1'b1;
        unique case (r_state)
          ST_IDLE: begin
            if (m_tlast) begin
              r_frame_len  <= LEN_W'(1);
              r_frame_done <= 1'b1;
            end else begin
              r_cnt   <= LEN_W'(1);
              r_state <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            if (m_tlast) begin
              r_frame_len  <= (r_cnt == CNT_MAX) ? CNT_MAX
                                                 : r_cnt + 1'b1;
              r_frame_done <= 1'b1;
              r_cnt        <= '0;
              r_state      <= ST_IDLE;
            end else if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qtree_stream_rx.sv
// Bench for qtree_stream_rx: queue model, directed and random traffic.
// Two instances (LEN_W=16 and LEN_W=3) share the same stimulus.
module tb_qtree_stream_rx;
  import qtree_stream_package::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  QTree_Int_t s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       m_tready;

  logic       a_srdy, a_mv, a_ml, a_fd, a_le;
  QTree_Int_t a_md;
  logic [15:0] a_fl;
  logic [3:0]  a_lvl;

  logic       b_srdy, b_mv, b_ml, b_fd, b_le;
  QTree_Int_t b_md;
  logic [2:0]  b_fl;
  logic [3:0]  b_lvl;

  qtree_stream_rx #(.DEPTH(8), .LEN_W(16)) dut_a (
    .aclk(clk), .areset(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(a_srdy),
    .m_tdata(a_md), .m_tvalid(a_mv), .m_tlast(a_ml),
    .m_tready(m_tready),
    .frame_done(a_fd), .frame_len(a_fl), .len_err(a_le),
    .level(a_lvl)
  );

  qtree_stream_rx #(.DEPTH(8), .LEN_W(3)) dut_b (
    .aclk(clk), .areset(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(b_srdy),
    .m_tdata(b_md), .m_tvalid(b_mv), .m_tlast(b_ml),
    .m_tready(m_tready),
    .frame_done(b_fd), .frame_len(b_fl), .len_err(b_le),
    .level(b_lvl)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: beat queue plus per-instance tree bookkeeping.
  QTreeBeat_t q[$];
  bit rdy;
  int cnt[2];
  bit e_fd[2];
  int e_fl[2];
  bit e_le[2];
  int mx[2] = '{65535, 7};

  task automatic chk(input string tag, input logic [67:0] obs,
                     input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; e_fd[k] = 1'b0; e_fl[k] = 0; e_le[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("s_tready_a", 68'(a_srdy), 68'(rdy && n != 8));
    chk("s_tready_b", 68'(b_srdy), 68'(rdy && n != 8));
    chk("m_tvalid_a", 68'(a_mv), 68'(n != 0));
    chk("m_tvalid_b", 68'(b_mv), 68'(n != 0));
    chk("level_a", 68'(a_lvl), 68'(n));
    chk("level_b", 68'(b_lvl), 68'(n));
    if (n > 0) begin
      chk("m_tdata_a", 68'(a_md), 68'(q[0].data));
      chk("m_tlast_a", 68'(a_ml), 68'(q[0].last));
      chk("m_tdata_b", 68'(b_md), 68'(q[0].data));
      chk("m_tlast_b", 68'(b_ml), 68'(q[0].last));
    end
    chk("frame_done_a", 68'(a_fd), 68'(e_fd[0]));
    chk("frame_done_b", 68'(b_fd), 68'(e_fd[1]));
    chk("frame_len_a", 68'(a_fl), 68'(e_fl[0]));
    chk("frame_len_b", 68'(b_fl), 68'(e_fl[1]));
    chk("len_err_a", 68'(a_le), 68'(e_le[0]));
    chk("len_err_b", 68'(b_le), 68'(e_le[1]));
  endtask

  function automatic QTree_Int_t rnd_tok();
    return QTree_Int_t'({$urandom(), $urandom(), $urandom()});
  endfunction

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic cycle(input bit v, input bit l, input QTree_Int_t d,
                       input bit r, output bit acc);
    bit push, pop;
    QTreeBeat_t f;
    s_tvalid = v; s_tlast = l; s_tdata = d; m_tready = r;
    push = v && rdy && (q.size() < 8);
    pop  = r && (q.size() > 0);
    @(posedge clk);
    for (int k = 0; k < 2; k++) e_fd[k] = 1'b0;
    if (pop) begin
      f = q.pop_front();
      for (int k = 0; k < 2; k++) begin
        cnt[k]++;
        if (cnt[k] > mx[k]) e_le[k] = 1'b1;
        if (f.last) begin
          e_fd[k] = 1'b1;
          e_fl[k] = (cnt[k] > mx[k]) ? mx[k] : cnt[k];
          cnt[k]  = 0;
        end
      end
    end
    if (push) q.push_back({l, d});
    rdy = 1'b1;
    acc = push;
    #1;
    check_all();
  endtask

  task automatic send(input bit l, input QTree_Int_t d,
                      input bit rnd_r, input bit r);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++)
      cycle(1'b1, l, d, rnd_r ? 1'($urandom_range(0, 1)) : r, acc);
    checks++;
    assert (acc) else begin
      failures++;
      $error("FAIL send_timeout observed=%0d expected=1", acc);
    end
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, rnd_tok(), r, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b0; m_tready = 1'b0;
    #1;
    clear_model();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    QTree_Int_t d9;
    rst = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
    clear_model();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b0);

    // 5-token tree, sink always ready.
    for (int i = 0; i < 5; i++) send(i == 4, rnd_tok(), 1'b0, 1'b1);
    idle(3, 1'b1);

    // Fill to DEPTH with sink stalled; ninth beat is held.
    for (int i = 0; i < 8; i++) send(1'b0, rnd_tok(), 1'b0, 1'b0);
    d9 = rnd_tok();
    cycle(1'b1, 1'b1, d9, 1'b0, acc);
    cycle(1'b1, 1'b1, d9, 1'b0, acc);
    // Pop while full: push refused, level 8 -> 7.
    cycle(1'b1, 1'b1, d9, 1'b1, acc);
    cycle(1'b1, 1'b1, d9, 1'b0, acc);
    idle(12, 1'b1);

    // Trees of 1 and 3 delivered back-to-back.
    send(1'b1, rnd_tok(), 1'b0, 1'b0);
    send(1'b0, rnd_tok(), 1'b0, 1'b0);
    send(1'b0, rnd_tok(), 1'b0, 1'b0);
    send(1'b1, rnd_tok(), 1'b0, 1'b0);
    idle(6, 1'b1);
    // Same shape with a random sink.
    send(1'b1, rnd_tok(), 1'b1, 1'b0);
    send(1'b0, rnd_tok(), 1'b1, 1'b0);
    send(1'b0, rnd_tok(), 1'b1, 1'b0);
    send(1'b1, rnd_tok(), 1'b1, 1'b0);
    idle(10, 1'b1);

    // 9-token tree overflows the 3-bit counter.
    for (int i = 0; i < 9; i++) send(i == 8, rnd_tok(), 1'b0, 1'b1);
    idle(3, 1'b1);
    send(1'b0, rnd_tok(), 1'b0, 1'b1);
    send(1'b1, rnd_tok(), 1'b0, 1'b1);
    idle(3, 1'b1);

    // Reset mid-tree with 4 beats buffered.
    for (int i = 0; i < 5; i++) send(1'b0, rnd_tok(), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, rnd_tok(), 1'b1, acc);
    do_reset();
    idle(1, 1'b0);
    send(1'b0, rnd_tok(), 1'b0, 1'b1);
    send(1'b1, rnd_tok(), 1'b0, 1'b1);
    idle(3, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 4) != 0, ($urandom % 4) == 0, rnd_tok(),
            ($urandom % 3) != 0, acc);
    idle(12, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qtree_stream_rx.md
QTREE_STREAM_RX -- requirements
Module: qtree_stream_rx

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, minimum 2.
REQ-002 The block SHALL have parameter LEN_W, default 16, meaning frame-length counter width.
REQ-003 The block SHALL have port aclk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 The block SHALL have port areset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port s_tdata, input, QTree_Int_t (67 bits): upstream QTree token.
REQ-006 The block SHALL have port s_tvalid, input, 1 bit: upstream token valid.
REQ-007 The block SHALL have port s_tlast, input, 1 bit: last token of a tree.
REQ-008 The block SHALL have port s_tready, output, 1 bit: block can accept a token.
REQ-009 The block SHALL have port m_tdata, output, QTree_Int_t: token presented to the core.
REQ-010 The block SHALL have port m_tvalid, output, 1 bit: m_tdata/m_tlast valid.
REQ-011 The block SHALL have port m_tlast, output, 1 bit: tlast carried with the token.
REQ-012 The block SHALL have port m_tready, input, 1 bit: core accepts the token.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after a tree completes at the output.
REQ-014 The block SHALL have port frame_len, output, LEN_W bits: token count of the last completed tree.
REQ-015 The block SHALL have port len_err, output, 1 bit: sticky flag set when a tree exceeds 2^LEN_W-1 tokens.
REQ-016 The block SHALL have port level, output, log2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-017 The block SHALL accept an input beat when s_tvalid and s_tready are both high at a rising edge, storing {s_tlast, s_tdata}.
REQ-018 The block SHALL drive s_tready = (level != DEPTH), combinationally from registered state only, with no dependence on m_tready.
REQ-019 The block SHALL drive m_tvalid = (level != 0); m_tdata/m_tlast SHALL be the oldest entry and SHALL hold stable while m_tvalid is high and m_tready is low.
REQ-020 The block SHALL have latency of 1 cycle: a beat accepted at edge N appears on m_* after edge N when the FIFO was empty; no combinational s_*-to-m_* path.
REQ-021 On simultaneous push and pop, level SHALL be unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 When full, a pop SHALL be allowed; s_tready rises the cycle after the pop.
REQ-023 The output FSM SHALL have states IDLE (no token of current tree delivered) and BUSY (at least one delivered).
REQ-024 In IDLE, a non-last output handshake SHALL go to BUSY with cnt=1; a last handshake SHALL stay IDLE and complete a 1-token tree.
REQ-025 In BUSY, each non-last handshake SHALL increment cnt; a last handshake SHALL complete the tree and return to IDLE.
REQ-026 On tree completion, frame_len SHALL load cnt+1 (saturated) and frame_done SHALL pulse high for exactly one cycle on the following cycle; frame_len SHALL hold until the next completion.
REQ-027 cnt SHALL saturate at 2^LEN_W-1; reaching saturation with a further handshake SHALL set len_err, which stays set until reset.
REQ-028 Back-to-back trees (last then first on consecutive cycles) SHALL be counted separately, with no lost pulse.

Reset
REQ-029 Asserting areset SHALL asynchronously clear pointers, level, cnt, frame_len, frame_done and len_err, and force FSM to IDLE.
REQ-030 During reset, s_tready=0 and m_tvalid=0; in-flight FIFO contents SHALL be discarded; m_tdata is don't-care.
REQ-031 s_tready SHALL rise on the first rising edge after areset deasserts.

Structure
REQ-032 QTree_Int_t (67 bits), QTREE_W, and the packed beat struct QTreeBeat_t {last, data} SHALL live in shared package qtree_stream_package.
REQ-033 Storage SHALL be a sub-module qtree_fifo (parameter DEPTH, QTreeBeat_t in/out, push/pop/level); the FSM and counters SHALL be in qtree_stream_rx.

Verification
REQ-034 The bench SHALL cover: a 5-token tree, tlast on beat 5, m_tready=1 -> 5 tokens in order, each 1 cycle after input; frame_done one pulse; frame_len=5.
REQ-035 The bench SHALL cover: m_tready=0 while 9 beats are offered, DEPTH=8 -> level=8, s_tready=0, 9th beat held; after one pop, s_tready=1 the next cycle and no data is lost.
REQ-036 The bench SHALL cover: two trees of 1 and 3 tokens, back-to-back, random m_tready -> two frame_done pulses, frame_len 1 then 3.
REQ-037 The bench SHALL cover: LEN_W=3 with a 9-token tree -> len_err=1 sticky; frame_len=7.
REQ-038 The bench SHALL cover: areset pulsed with 4 entries buffered and the FSM in BUSY -> level=0, m_tvalid=0, IDLE; the next 2-token tree reports frame_len=2.
REQ-039 The bench SHALL cover: a full FIFO with simultaneous pop and offered push -> pop occurs, push is refused that cycle, and level goes 8 -> 7.
